// File: rtl/trace_collector.sv
// Commit-trace collector: captures register/memory writes into a record FIFO and streams them
// as 32-bit words. Define TRACE_TIMESTAMP_EN to add a cycle-stamp word to every record.
module trace_collector #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic [31:0]              pc,
    input  logic                     RegWrite,
    input  logic [4:0]               RegAddr,
    input  logic [31:0]              RegData,
    input  logic                     MemWrite,
    input  logic [31:0]              MemAddr,
    input  logic [31:0]              MemData,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic                     out_last,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic        is_mem;
        logic [4:0]  addr;
        logic [31:0] pc;
        logic [31:0] d2;
        logic [31:0] d3;
`ifdef TRACE_TIMESTAMP_EN
        logic [31:0] ts;
`endif
    } rec_t;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
`ifdef TRACE_TIMESTAMP_EN
        StTs,
`endif
        StPc,
        StW2,
        StW3
    } state_t;

    state_t            state_q, state_d;
    rec_t              mem_q [DEPTH];
    rec_t              rec_q;
    rec_t              reg_rec, mem_rec, first_rec;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q, wr_ptr_nxt;
    logic [AW:0]       count_q, free_slots;
    logic [CNT_W-1:0]  drop_q;
    logic [CNT_W:0]    drop_sum;
    logic              reg_ev, mem_ev, fits, deq;
    logic [1:0]        need, enq_n, drop_n;
    logic [31:0]       hdr;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]       ts_q;
`endif

    always_comb begin
        reg_ev     = trace_en && RegWrite && (RegAddr != 5'd0);
        mem_ev     = trace_en && MemWrite;
        need       = {1'b0, reg_ev} + {1'b0, mem_ev};
        // Space is judged on the count at the start of the cycle; a same-cycle pop does not help.
        free_slots = (AW + 1)'(DEPTH) - count_q;
        fits       = (AW + 1)'(need) <= free_slots;
        enq_n      = fits ? need : 2'd0;
        drop_n     = fits ? 2'd0 : need;
        deq        = (state_q == StIdle) && (count_q != '0);
        wr_ptr_nxt = wr_ptr_q + AW'(1);
        drop_sum   = {1'b0, drop_q} + (CNT_W + 1)'(drop_n);

        reg_rec        = '0;
        reg_rec.is_mem = 1'b0;
        reg_rec.addr   = RegAddr;
        reg_rec.pc     = pc;
        reg_rec.d2     = RegData;
        mem_rec        = '0;
        mem_rec.is_mem = 1'b1;
        mem_rec.pc     = pc;
        mem_rec.d2     = MemAddr;
        mem_rec.d3     = MemData;
`ifdef TRACE_TIMESTAMP_EN
        reg_rec.ts     = ts_q;
        mem_rec.ts     = ts_q;
`endif
        first_rec      = reg_ev ? reg_rec : mem_rec;
    end

    // Record storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (enq_n != 2'd0) begin
            mem_q[wr_ptr_q] <= first_rec;
            if (enq_n == 2'd2) begin
                mem_q[wr_ptr_nxt] <= mem_rec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            rec_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_q + AW'(enq_n);
            count_q  <= count_q + (AW + 1)'(enq_n) - (AW + 1)'(deq);
            drop_q   <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            if (deq) begin
                rec_q    <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end
`endif

    // Outside IDLE the word is always valid, so a handshake is just out_ready.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (count_q != '0) state_d = StHdr;
            StHdr: begin
                if (out_ready) begin
`ifdef TRACE_TIMESTAMP_EN
                    state_d = StTs;
`else
                    state_d = StPc;
`endif
                end
            end
`ifdef TRACE_TIMESTAMP_EN
            StTs:   if (out_ready) state_d = StPc;
`endif
            StPc:   if (out_ready) state_d = StW2;
            StW2:   if (out_ready) state_d = rec_q.is_mem ? StW3 : StIdle;
            StW3:   if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hdr = rec_q.is_mem ? 32'h8000_0000 : {2'b01, 25'b0, rec_q.addr};
`ifdef TRACE_TIMESTAMP_EN
        hdr[29] = 1'b1;
`endif
        out_valid = (state_q != StIdle);
        out_last  = 1'b0;
        out_data  = 32'h0;
        unique case (state_q)
            StHdr: out_data = hdr;
`ifdef TRACE_TIMESTAMP_EN
            StTs:  out_data = rec_q.ts;
`endif
            StPc:  out_data = rec_q.pc;
            StW2: begin
                out_data = rec_q.d2;
                out_last = !rec_q.is_mem;
            end
            StW3: begin
                out_data = rec_q.d3;
                out_last = 1'b1;
            end
            default: out_data = 32'h0;
        endcase
    end

    assign drop_cnt   = drop_q;
    assign fifo_count = count_q;

endmodule
